// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared defaults and stage record for the FP pipeline controller
package fpu_pkg;

    localparam int FLEN            = 32;
    localparam int XLEN            = 32;
    localparam int NUM_FPU_REGS    = 32;
    localparam int FPU_PIPE_STAGES = 4;
    localparam int FPU_ID_WIDTH    = 4;
    localparam int FPU_REG_AW      = $clog2(NUM_FPU_REGS);
    localparam int FPU_NUM_SRCS    = 3;

    // One pipeline slot at the default widths
    typedef struct packed {
        logic                    valid;
        logic [FPU_ID_WIDTH-1:0] id;
        logic [FPU_REG_AW-1:0]   rd;
        logic                    to_xreg;
        logic [FLEN-1:0]         data;
    } fpu_stage_t;

endpackage

// File: rtl/fpu_pipe_ctrl_if.sv
// rtl/fpu_pipe_ctrl_if.sv - issue and result handshake bundle for fpu_pipe_ctrl
interface fpu_pipe_ctrl_if #(
    parameter int X_ID_WIDTH = fpu_pkg::FPU_ID_WIDTH,
    parameter int NUM_REGS   = fpu_pkg::NUM_FPU_REGS,
    parameter int FLEN       = fpu_pkg::FLEN
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int NS = fpu_pkg::FPU_NUM_SRCS;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [RW-1:0]         issue_rd;
    logic [NS*RW-1:0]      issue_rs;
    logic [NS-1:0]         issue_rs_used;
    logic                  issue_to_xreg;
    logic [FLEN-1:0]       issue_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [X_ID_WIDTH-1:0] res_id;
    logic [RW-1:0]         res_rd;
    logic                  res_to_xreg;
    logic [FLEN-1:0]       res_data;

    modport master (
        output issue_valid, issue_id, issue_rd, issue_rs, issue_rs_used,
               issue_to_xreg, issue_data, res_ready,
        input  issue_ready, res_valid, res_id, res_rd, res_to_xreg, res_data
    );

    modport slave (
        input  issue_valid, issue_id, issue_rd, issue_rs, issue_rs_used,
               issue_to_xreg, issue_data, res_ready,
        output issue_ready, res_valid, res_id, res_rd, res_to_xreg, res_data
    );

endinterface

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - pending FP destination bits with RAW/WAW hazard check
module fpu_scoreboard #(
    parameter int NUM_REGS = fpu_pkg::NUM_FPU_REGS,
    parameter int NS       = fpu_pkg::FPU_NUM_SRCS,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                clr_all,
    input  logic                set_en,
    input  logic [RW-1:0]       set_idx,
    input  logic                clr_en,
    input  logic [RW-1:0]       clr_idx,
    input  logic [NS*RW-1:0]    rs,
    input  logic [NS-1:0]       rs_used,
    input  logic [RW-1:0]       rd,
    input  logic                rd_check,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Next mask: retire clears, issue sets; WAW stalls keep the two indices distinct
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_idx] = 1'b0;
        if (set_en) pending_d[set_idx] = 1'b1;
        if (clr_all) pending_d = '0;
    end

    // Hazard looks only at the registered mask, so a same-cycle retire does not bypass
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (rs_used[k] && pending_q[rs[k*RW +: RW]]) hazard = 1'b1;
        end
        if (rd_check && pending_q[rd]) hazard = 1'b1;
    end

    // Mask register
    always_ff @(posedge ck) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// rtl/fpu_pipe_ctrl.sv - in-order issue/retire pipeline with destination scoreboard
module fpu_pipe_ctrl #(
    parameter int PIPELINE_STAGES = fpu_pkg::FPU_PIPE_STAGES,
    parameter int NUM_REGS        = fpu_pkg::NUM_FPU_REGS,
    parameter int X_ID_WIDTH      = fpu_pkg::FPU_ID_WIDTH,
    parameter int FLEN            = fpu_pkg::FLEN
) (
    input  logic                                 ck,
    input  logic                                 rst,
    input  logic                                 flush,
    fpu_pipe_ctrl_if.slave                       bus,
    output logic [NUM_REGS-1:0]                  pending_mask,
    output logic [$clog2(PIPELINE_STAGES+1)-1:0] occupancy,
    output logic                                 busy
);
    import fpu_pkg::*;

    localparam int RW    = $clog2(NUM_REGS);
    localparam int OCC_W = $clog2(PIPELINE_STAGES + 1);
    localparam int LAST  = PIPELINE_STAGES - 1;
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(PIPELINE_STAGES);

    typedef struct packed {
        logic                  valid;
        logic [X_ID_WIDTH-1:0] id;
        logic [RW-1:0]         rd;
        logic                  to_xreg;
        logic [FLEN-1:0]       data;
    } stage_t;

    stage_t [PIPELINE_STAGES-1:0] stage_q;
    stage_t [PIPELINE_STAGES-1:0] stage_d;
    logic   [OCC_W-1:0]           occupancy_q;
    logic   [OCC_W-1:0]           occupancy_d;
    logic   [PIPELINE_STAGES-1:0] ready_in;
    logic                         hazard;
    logic                         issue_fire;
    logic                         retire;

    // A stage can take new content when empty or when its own content leaves
    always_comb begin
        ready_in[LAST] = !stage_q[LAST].valid || bus.res_ready;
        for (int i = PIPELINE_STAGES - 2; i >= 0; i--) begin
            ready_in[i] = !stage_q[i].valid || ready_in[i+1];
        end
    end

    // Issue handshake and retire detection
    always_comb begin
        bus.issue_ready = rst && !flush && !hazard && ready_in[0];
        issue_fire      = bus.issue_valid && bus.issue_ready;
        retire          = stage_q[LAST].valid && bus.res_ready;
    end

    // Bubble-collapsing shift; flush empties every slot
    always_comb begin
        stage_d = stage_q;
        if (ready_in[0]) begin
            stage_d[0] = '0;
            if (issue_fire) begin
                stage_d[0].valid   = 1'b1;
                stage_d[0].id      = bus.issue_id;
                stage_d[0].rd      = bus.issue_rd;
                stage_d[0].to_xreg = bus.issue_to_xreg;
                stage_d[0].data    = bus.issue_data;
            end
        end
        for (int i = 1; i < PIPELINE_STAGES; i++) begin
            if (ready_in[i]) stage_d[i] = stage_q[i-1];
        end
        if (flush) stage_d = '0;
    end

    // In-flight count: simultaneous accept and retire cancel
    always_comb begin
        occupancy_d = occupancy_q;
        if (issue_fire && !retire)      occupancy_d = occupancy_q + OCC_ONE;
        else if (!issue_fire && retire) occupancy_d = occupancy_q - OCC_ONE;
        if (flush) occupancy_d = '0;
    end

    // Pipeline and counter registers
    always_ff @(posedge ck) begin
        if (!rst) begin
            stage_q     <= '0;
            occupancy_q <= '0;
        end else begin
            stage_q     <= stage_d;
            occupancy_q <= occupancy_d;
        end
    end

    fpu_scoreboard #(.NUM_REGS(NUM_REGS), .NS(FPU_NUM_SRCS)) u_scoreboard (
        .ck       (ck),
        .rst      (rst),
        .clr_all  (flush),
        .set_en   (issue_fire && !bus.issue_to_xreg),
        .set_idx  (bus.issue_rd),
        .clr_en   (retire && !stage_q[LAST].to_xreg),
        .clr_idx  (stage_q[LAST].rd),
        .rs       (bus.issue_rs),
        .rs_used  (bus.issue_rs_used),
        .rd       (bus.issue_rd),
        .rd_check (!bus.issue_to_xreg),
        .hazard   (hazard),
        .pending  (pending_mask)
    );

    assign bus.res_valid   = stage_q[LAST].valid;
    assign bus.res_id      = stage_q[LAST].id;
    assign bus.res_rd      = stage_q[LAST].rd;
    assign bus.res_to_xreg = stage_q[LAST].to_xreg;
    assign bus.res_data    = stage_q[LAST].data;
    assign occupancy       = occupancy_q;
    assign busy            = (occupancy_q != '0);

    occupancy_bound: assert property (@(posedge ck) disable iff (!rst) occupancy_q <= OCC_MAX);

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// tb/tb_fpu_pipe_ctrl.sv - directed self-checking bench for fpu_pipe_ctrl
module tb_fpu_pipe_ctrl;

    logic        ck = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pending_mask;
    logic [2:0]  occupancy;
    logic        busy;
    int          vectors = 0;
    int          miscompares = 0;

    fpu_pipe_ctrl_if #(.X_ID_WIDTH(4), .NUM_REGS(32), .FLEN(32)) bus ();

    fpu_pipe_ctrl #(.PIPELINE_STAGES(4), .NUM_REGS(32), .X_ID_WIDTH(4), .FLEN(32)) dut (
        .ck           (ck),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .pending_mask (pending_mask),
        .occupancy    (occupancy),
        .busy         (busy)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic drive_issue(input logic [3:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [2:0] used, input logic xr, input logic [31:0] data);
        bus.issue_valid   = 1'b1;
        bus.issue_id      = id;
        bus.issue_rd      = rd;
        bus.issue_rs      = {10'd0, rs1};
        bus.issue_rs_used = used;
        bus.issue_to_xreg = xr;
        bus.issue_data    = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        bus.res_ready = 1'b1;
        drive_issue(4'd9, 5'd3, 5'd0, 3'b000, 1'b0, 32'hDEADBEEF);
        step(); step(); step();
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %0h exp 0", bus.res_valid); end
        vectors++; if ({bus.res_id, bus.res_rd, bus.res_to_xreg} !== 10'd0) begin miscompares++; $display("FAIL reset_res_fields got %0h exp 0", {bus.res_id, bus.res_rd, bus.res_to_xreg}); end
        vectors++; if (bus.res_data !== 32'd0) begin miscompares++; $display("FAIL reset_res_data got %0h exp 0", bus.res_data); end
        vectors++; if (pending_mask !== 32'd0) begin miscompares++; $display("FAIL reset_pending got %0h exp 0", pending_mask); end
        vectors++; if (occupancy !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_occ got %0d/%0b exp 0/0", occupancy, busy); end
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL reset_issue_ready got %0b exp 0", bus.issue_ready); end
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL release_issue_ready got %0b exp 1", bus.issue_ready); end
    endtask

    task automatic test_single();
        bus.res_ready = 1'b0;
        drive_issue(4'd3, 5'd5, 5'd0, 3'b000, 1'b0, 32'h3F800000);
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got %0b exp 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        vectors++; if (pending_mask !== 32'h0000_0020) begin miscompares++; $display("FAIL single_pending got %0h exp 20", pending_mask); end
        vectors++; if (occupancy !== 3'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL single_occ got %0d/%0b exp 1/1", occupancy, busy); end
        for (int c = 0; c < 3; c++) begin
            vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid cycle %0d got %0b exp 0", c, bus.res_valid); end
            step();
        end
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 4'd3 || bus.res_rd !== 5'd5 || bus.res_to_xreg !== 1'b0) begin
            miscompares++; $display("FAIL single_result got v=%0b id=%0d rd=%0d x=%0b exp v=1 id=3 rd=5 x=0", bus.res_valid, bus.res_id, bus.res_rd, bus.res_to_xreg); end
        vectors++; if (bus.res_data !== 32'h3F800000) begin miscompares++; $display("FAIL single_data got %0h exp 3f800000", bus.res_data); end
        step();
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h3F800000 || pending_mask !== 32'h20) begin
            miscompares++; $display("FAIL single_hold got v=%0b d=%0h pm=%0h exp v=1 d=3f800000 pm=20", bus.res_valid, bus.res_data, pending_mask); end
        bus.res_ready = 1'b1;
        step();
        vectors++; if (bus.res_valid !== 1'b0 || pending_mask !== 32'd0 || occupancy !== 3'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL single_retire got v=%0b pm=%0h occ=%0d busy=%0b exp 0 0 0 0", bus.res_valid, pending_mask, occupancy, busy); end
    endtask

    task automatic test_back_to_back();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_issue(4'(i + 1), 5'(i + 1), 5'd0, 3'b000, 1'b0, 32'h1000 + i);
            step();
            vectors++; if (occupancy !== 3'(i + 1)) begin miscompares++; $display("FAIL b2b_occ step %0d got %0d exp %0d", i, occupancy, i + 1); end
        end
        bus.issue_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 4'(j + 1) || bus.res_data !== 32'h1000 + j) begin
                miscompares++; $display("FAIL b2b_result %0d got v=%0b id=%0d d=%0h exp v=1 id=%0d d=%0h", j, bus.res_valid, bus.res_id, bus.res_data, j + 1, 32'h1000 + j); end
            step();
        end
        vectors++; if (bus.res_valid !== 1'b0 || occupancy !== 3'd0 || pending_mask !== 32'd0) begin
            miscompares++; $display("FAIL b2b_drained got v=%0b occ=%0d pm=%0h exp 0 0 0", bus.res_valid, occupancy, pending_mask); end
    endtask

    task automatic test_full();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(4'(i + 8), 5'(i + 10), 5'd0, 3'b000, 1'b0, 32'hA0 + i);
            #1;
            vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL full_fill_ready %0d got %0b exp 1", i, bus.issue_ready); end
            step();
        end
        drive_issue(4'd12, 5'd14, 5'd0, 3'b000, 1'b0, 32'hA4);
        #1;
        vectors++; if (bus.issue_ready !== 1'b0 || occupancy !== 3'd4) begin
            miscompares++; $display("FAIL full_stall got rdy=%0b occ=%0d exp 0 4", bus.issue_ready, occupancy); end
        step();
        vectors++; if (bus.issue_ready !== 1'b0 || bus.res_id !== 4'd8 || bus.res_data !== 32'hA0) begin
            miscompares++; $display("FAIL full_hold got rdy=%0b id=%0d d=%0h exp 0 8 a0", bus.issue_ready, bus.res_id, bus.res_data); end
        bus.res_ready = 1'b1;
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL full_reassert got %0b exp 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL full_occ_swap got %0d exp 4", occupancy); end
        for (int j = 0; j < 4; j++) begin
            vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 4'(j + 9)) begin
                miscompares++; $display("FAIL full_drain %0d got v=%0b id=%0d exp v=1 id=%0d", j, bus.res_valid, bus.res_id, j + 9); end
            step();
        end
        vectors++; if (bus.res_valid !== 1'b0 || occupancy !== 3'd0 || pending_mask !== 32'd0) begin
            miscompares++; $display("FAIL full_empty got v=%0b occ=%0d pm=%0h exp 0 0 0", bus.res_valid, occupancy, pending_mask); end
    endtask

    task automatic test_raw();
        bus.res_ready = 1'b1;
        drive_issue(4'd1, 5'd7, 5'd0, 3'b000, 1'b0, 32'h77);
        step();
        drive_issue(4'd2, 5'd9, 5'd7, 3'b001, 1'b0, 32'h99);
        #1;
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall0 got %0b exp 0", bus.issue_ready); end
        for (int c = 1; c <= 3; c++) begin
            step();
            vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall%0d got %0b exp 0", c, bus.issue_ready); end
        end
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 4'd1) begin
            miscompares++; $display("FAIL raw_first_result got v=%0b id=%0d exp 1 1", bus.res_valid, bus.res_id); end
        step();
        vectors++; if (bus.issue_ready !== 1'b1 || pending_mask[7] !== 1'b0) begin
            miscompares++; $display("FAIL raw_release got rdy=%0b pm7=%0b exp 1 0", bus.issue_ready, pending_mask[7]); end
        step();
        bus.issue_valid = 1'b0;
        vectors++; if (occupancy !== 3'd1 || pending_mask !== 32'h0000_0200) begin
            miscompares++; $display("FAIL raw_accepted got occ=%0d pm=%0h exp 1 200", occupancy, pending_mask); end
        drive_issue(4'd3, 5'd7, 5'd0, 3'b000, 1'b1, 32'h33);
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_xreg_ready got %0b exp 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        vectors++; if (pending_mask !== 32'h0000_0200 || occupancy !== 3'd2) begin
            miscompares++; $display("FAIL raw_xreg_nobit got pm=%0h occ=%0d exp 200 2", pending_mask, occupancy); end
        for (int c = 0; c < 8; c++) step();
        vectors++; if (occupancy !== 3'd0 || pending_mask !== 32'd0) begin
            miscompares++; $display("FAIL raw_drained got occ=%0d pm=%0h exp 0 0", occupancy, pending_mask); end
    endtask

    task automatic test_flush();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_issue(4'(i + 4), 5'(i + 20), 5'd0, 3'b000, 1'b0, 32'hF0 + i);
            step();
        end
        bus.issue_valid = 1'b0;
        vectors++; if (occupancy !== 3'd3 || pending_mask !== 32'h0070_0000) begin
            miscompares++; $display("FAIL flush_pre got occ=%0d pm=%0h exp 3 700000", occupancy, pending_mask); end
        flush = 1'b1;
        drive_issue(4'd7, 5'd23, 5'd0, 3'b000, 1'b0, 32'hF3);
        #1;
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %0b exp 0", bus.issue_ready); end
        step();
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        vectors++; if (bus.res_valid !== 1'b0 || occupancy !== 3'd0 || pending_mask !== 32'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_post got v=%0b occ=%0d pm=%0h busy=%0b exp 0 0 0 0", bus.res_valid, occupancy, pending_mask, busy); end
        drive_issue(4'd5, 5'd20, 5'd0, 3'b000, 1'b0, 32'h55);
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL flush_reissue_ready got %0b exp 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        step(); step();
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL flush_early got %0b exp 0", bus.res_valid); end
        step();
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 4'd5 || bus.res_rd !== 5'd20) begin
            miscompares++; $display("FAIL flush_latency got v=%0b id=%0d rd=%0d exp 1 5 20", bus.res_valid, bus.res_id, bus.res_rd); end
        bus.res_ready = 1'b1;
        step();
        vectors++; if (occupancy !== 3'd0 || pending_mask !== 32'd0) begin
            miscompares++; $display("FAIL flush_final got occ=%0d pm=%0h exp 0 0", occupancy, pending_mask); end
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_raw();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_pipe_ctrl.md
# fpu_pipe_ctrl

Parametrised issue/retire controller for the floating-point coprocessor pipeline. It carries each accepted instruction's tag (id, destination, writeback target, precomputed result) through a configurable number of stages. It tracks in-flight FP destination registers in a scoreboard to stall RAW/WAW hazards, and presents results in order under valid/ready backpressure. It sits between the core-side instruction interface and the FP register file / integer writeback path, replacing the fixed single-stage enable-driven operation call.

## Interface
- PIPELINE_STAGES, 4: pipeline depth, ≥1
- NUM_REGS, 32: FP register count
- X_ID_WIDTH, 4: instruction id width
- FLEN, 32: result data width
- ck  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-low
- flush  in  1  discard all in-flight instructions
- issue_valid  in  1  instruction offered
- issue_ready  out  1  instruction accepted when both high
- issue_id  in  X_ID_WIDTH  instruction id
- issue_rd  in  $clog2(NUM_REGS)  destination register
- issue_rs  in  3×$clog2(NUM_REGS)  FP sources rs1..rs3
- issue_rs_used  in  3  per-source FP-read enable
- issue_to_xreg  in  1  1: result goes to integer reg (rd not tracked)
- issue_data  in  FLEN  result payload
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_id, res_rd, res_to_xreg, res_data  out  as issue  retiring entry fields
- pending_mask  out  NUM_REGS  scoreboard bits
- occupancy  out  $clog2(PIPELINE_STAGES+1)  valid entries in flight
- busy  out  1  occupancy ≠ 0

## Operation
- Stage i holds {valid, id, rd, to_xreg, data}. Stage PIPELINE_STAGES-1 drives res_*.
- Bubble-collapsing advance: last stage may move if !valid or res_ready. Stage i may move if stage i+1 is empty or moving.
- Hazard: any used rs_k with pending_mask[rs_k]=1 (RAW), or !issue_to_xreg and pending_mask[issue_rd]=1 (WAW).
- issue_ready = rst & !flush & !hazard & (stage0 empty or moving). Combinational; no dependence on issue_valid.
- Scoreboard set on accepted issue with !issue_to_xreg. Cleared on res handshake with !res_to_xreg. There is no bypass: an issue reading a register retiring in the same cycle stalls one cycle.
- occupancy changes +1 on accept, −1 on retire, 0 when both occur.
- Flush: on that edge all valids and pending_mask clear. A res handshake in the flush cycle still counts as delivered. No issue is accepted.
- Reset (rst=0): same clearing as flush. Outputs read 0 in the following cycle: res_valid, res_* fields, pending_mask, occupancy and busy. issue_ready=0 while rst=0. Reset mid-operation drops all entries silently.

## Timing
- Latency: an issue accepted at edge k gives res_valid high after edge k+PIPELINE_STAGES-1 (PIPELINE_STAGES=1: the cycle after issue) when unstalled.
- Throughput is 1 per cycle. Results retire strictly in issue order.
- res_* are held stable while res_valid & !res_ready.
- Full: occupancy = PIPELINE_STAGES and last stage stalled → issue_ready=0. It reasserts in the same cycle that res_ready rises.
- The occupancy counter never exceeds PIPELINE_STAGES and never wraps. An assertion covers this.

## Structure
- fpu_pkg: FLEN, XLEN, NUM_FPU_REGS, FPU_PIPE_STAGES defaults; fpu_stage_t packed struct {valid, id, rd, to_xreg, data}.
- Sub-module fpu_scoreboard: the NUM_REGS bit vector with set/clear/clear-all ports and 3-source + rd hazard check.

## Test plan
- Reset: hold rst=0 with valid stimulus → all outputs 0, issue_ready=0. Release → issue_ready=1.
- Single issue id=3, rd=5, data=0x3F800000, STAGES=4 → res_valid after 4 cycles carrying id=3, rd=5, data=0x3F800000. pending_mask[5]=1 until the handshake.
- Four independent back-to-back issues with res_ready=1 → four results on consecutive cycles in order, occupancy peaks at 4.
- res_ready=0, offer 5 independent → 4 accepted, 5th sees issue_ready=0, occupancy=4. Raise res_ready → 5th accepted the same cycle and all drain in order.
- RAW: issue rd=7, then rs1=7 → second stalls until the first retires and is accepted the cycle after the retire handshake. A to_xreg=1 write to rd=7 sets no bit.
- Flush with 3 in flight and mask bits set → the next cycle has res_valid=0, occupancy=0, pending_mask=0. A following issue has normal latency.
